// File: rtl/prog_sequence_detector.sv
// Serial-bit pattern detector with a bank of runtime-programmable patterns.
//
// A bank of NUM_PAT slots, each PAT_LEN bits wide, is written through the
// pat_wr port. lookfor_seq picks the slot that incoming bits are compared
// against. Bit PAT_LEN-1 of a pattern is the first bit received. Each match
// gives a one-cycle seq_detected pulse and increments a saturating counter.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   input_seq    serial data bit, consumed only when in_valid is high
//   in_valid     qualifies input_seq
//   lookfor_seq  active pattern slot select
//   overlap_en   1: overlapping matches are counted, 0: non-overlapping
//   pat_wr       pattern bank write strobe
//   pat_wr_sel   slot being written
//   pat_wr_data  pattern value, MSB first
//   seq_detected registered one-cycle match pulse
//   dseq_count   matches since the last clear, saturating
//   count_sat    high while dseq_count is all ones
module prog_sequence_detector #(
    parameter int unsigned PAT_LEN = 5,
    parameter int unsigned NUM_PAT = 4,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned SEL_W  = $clog2(NUM_PAT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               input_seq,
    input  logic               in_valid,
    input  logic [SEL_W-1:0]   lookfor_seq,
    input  logic               overlap_en,
    input  logic               pat_wr,
    input  logic [SEL_W-1:0]   pat_wr_sel,
    input  logic [PAT_LEN-1:0] pat_wr_data,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   dseq_count,
    output logic               count_sat
);

    localparam int unsigned FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FillFull = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FillLast = FILL_W'(PAT_LEN - 1);

    logic [PAT_LEN-1:0] slot_q [NUM_PAT];
    logic [NUM_PAT-1:0] slot_valid_q;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [PAT_LEN-1:0] nxt;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [SEL_W-1:0]   sel_q;
    logic               det_q, det_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic               clear;
    logic               match;

    always_comb begin
        // A slot change or a rewrite of the active slot restarts detection.
        clear = (lookfor_seq != sel_q) || (pat_wr && (pat_wr_sel == lookfor_seq));
        nxt   = {hist_q[PAT_LEN-2:0], input_seq};
        // fill counts bits received since the last restart; a match needs the
        // whole window to consist of such bits, including the current one.
        match = in_valid && !clear && slot_valid_q[lookfor_seq] &&
                (fill_q >= FillLast) && (nxt == slot_q[lookfor_seq]);

        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        det_d  = 1'b0;

        if (clear) begin
            fill_d = '0;
            cnt_d  = '0;
        end else if (in_valid) begin
            hist_d = nxt;
            fill_d = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;
            if (match) begin
                det_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (!overlap_en) begin
                    fill_d = '0;
                end
            end
        end

        sat_d = &cnt_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_PAT); i++) begin
                slot_q[i] <= '0;
            end
            slot_valid_q <= '0;
            hist_q       <= '0;
            fill_q       <= '0;
            sel_q        <= lookfor_seq;
            det_q        <= 1'b0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
        end else begin
            if (pat_wr) begin
                slot_q[pat_wr_sel]       <= pat_wr_data;
                slot_valid_q[pat_wr_sel] <= 1'b1;
            end
            hist_q <= hist_d;
            fill_q <= fill_d;
            sel_q  <= lookfor_seq;
            det_q  <= det_d;
            cnt_q  <= cnt_d;
            sat_q  <= sat_d;
        end
    end

    assign seq_detected = det_q;
    assign dseq_count   = cnt_q;
    assign count_sat    = sat_q;

endmodule

// File: tb/tb_prog_sequence_detector.sv
// Self-checking bench for prog_sequence_detector. Two instances share all
// inputs: one with the default 16-bit counter and one with a 3-bit counter so
// saturation is reachable. A window-of-received-bits model predicts outputs.
module tb_prog_sequence_detector;

    localparam int PAT_LEN = 5;
    localparam int NUM_PAT = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       input_seq = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] lookfor_seq = 2'd0;
    logic       overlap_en = 1'b0;
    logic       pat_wr = 1'b0;
    logic [1:0] pat_wr_sel = 2'd0;
    logic [4:0] pat_wr_data = 5'd0;

    logic        det_a, sat_a, det_b, sat_b;
    logic [15:0] cnt_a;
    logic [2:0]  cnt_b;

    always #5 clk = ~clk;

    prog_sequence_detector #(.PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .CNT_W(16)) dut_a (
        .clk          (clk),
        .reset        (reset),
        .input_seq    (input_seq),
        .in_valid     (in_valid),
        .lookfor_seq  (lookfor_seq),
        .overlap_en   (overlap_en),
        .pat_wr       (pat_wr),
        .pat_wr_sel   (pat_wr_sel),
        .pat_wr_data  (pat_wr_data),
        .seq_detected (det_a),
        .dseq_count   (cnt_a),
        .count_sat    (sat_a)
    );

    prog_sequence_detector #(.PAT_LEN(PAT_LEN), .NUM_PAT(NUM_PAT), .CNT_W(3)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .input_seq    (input_seq),
        .in_valid     (in_valid),
        .lookfor_seq  (lookfor_seq),
        .overlap_en   (overlap_en),
        .pat_wr       (pat_wr),
        .pat_wr_sel   (pat_wr_sel),
        .pat_wr_data  (pat_wr_data),
        .seq_detected (det_b),
        .dseq_count   (cnt_b),
        .count_sat    (sat_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the bits received since the last restart (last PAT_LEN kept),
    // and the total number of matches since the last clear.
    logic [4:0] m_slot [NUM_PAT];
    logic [3:0] m_valid;
    logic [1:0] m_sel;
    bit         m_win [$];
    logic       m_det;
    int         m_total;
    logic       m_clr;
    logic [4:0] m_v;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAT; i++) m_slot[i] = '0;
            m_valid = '0;
            m_win.delete();
            m_det   = 1'b0;
            m_total = 0;
        end else begin
            m_clr = (lookfor_seq != m_sel) || (pat_wr && pat_wr_sel == lookfor_seq);
            m_det = 1'b0;
            if (m_clr) begin
                m_total = 0;
                m_win.delete();
            end else if (in_valid) begin
                m_win.push_back(input_seq);
                if (m_win.size() > PAT_LEN) void'(m_win.pop_front());
                m_v = '0;
                for (int i = 0; i < m_win.size(); i++) m_v = {m_v[3:0], m_win[i]};
                if (m_valid[lookfor_seq] && m_win.size() == PAT_LEN &&
                    m_v == m_slot[lookfor_seq]) begin
                    m_det = 1'b1;
                    m_total++;
                    if (!overlap_en) m_win.delete();
                end
            end
            if (pat_wr) begin
                m_slot[pat_wr_sel]  = pat_wr_data;
                m_valid[pat_wr_sel] = 1'b1;
            end
        end
        m_sel = lookfor_seq;
    end

    bit chk_en = 1'b0;
    int exp_a, exp_b;

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            exp_a = (m_total > 65535) ? 65535 : m_total;
            exp_b = (m_total > 7) ? 7 : m_total;
            check("det_a", det_a, m_det);
            check("cnt_a", cnt_a, exp_a);
            check("sat_a", sat_a, exp_a == 65535);
            check("det_b", det_b, m_det);
            check("cnt_b", cnt_b, exp_b);
            check("sat_b", sat_b, exp_b == 7);
        end
    end

    task automatic cyc(input logic b, input logic v);
        @(negedge clk);
        input_seq = b;
        in_valid  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic write_pat(input logic [1:0] sel, input logic [4:0] data);
        @(negedge clk);
        in_valid    = 1'b0;
        pat_wr      = 1'b1;
        pat_wr_sel  = sel;
        pat_wr_data = data;
        @(posedge clk);
        #1;
        pat_wr = 1'b0;
    endtask

    // ma/mb bit i = pulse seen after bit i+1 of the stream (MSB first).
    task automatic send(input logic [15:0] bits, input int n,
                        output logic [15:0] ma, output logic [15:0] mb);
        ma = '0;
        mb = '0;
        for (int i = 0; i < n; i++) begin
            cyc(bits[n-1-i], 1'b1);
            ma[i] = det_a;
            mb[i] = det_b;
        end
    endtask

    task automatic send_bubbled(input logic [15:0] bits, input int n, output logic [15:0] ma);
        ma = '0;
        for (int i = 0; i < n; i++) begin
            cyc(bits[n-1-i], 1'b1);
            ma[i] = det_a;
            cyc(1'b0, 1'b0);
        end
    endtask

    logic [15:0] ma, mb;

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(posedge clk);
        #1;
        check("rst_det", det_a, 0);
        check("rst_cnt", cnt_a, 0);
        check("rst_sat", sat_a, 0);
        reset = 1'b0;

        // 1: non-overlapping then overlapping on slot 0
        write_pat(2'd0, 5'b10111);
        overlap_en = 1'b0;
        send(16'b101110111, 9, ma, mb);
        check("s1_mask_nov", ma, 16'h0010);
        check("s1_cnt_nov", cnt_a, 1);
        write_pat(2'd0, 5'b10111);
        overlap_en = 1'b1;
        send(16'b101110111, 9, ma, mb);
        check("s1_mask_ov", ma, 16'h0110);
        check("s1_cnt_ov", cnt_a, 2);

        // 2: slot 1, switch and write on the same edge
        lookfor_seq = 2'd1;
        write_pat(2'd1, 5'b01010);
        overlap_en = 1'b0;
        send(16'b0101010, 7, ma, mb);
        check("s2_mask_nov", ma, 16'h0010);
        check("s2_cnt_nov", cnt_a, 1);
        write_pat(2'd1, 5'b01010);
        overlap_en = 1'b1;
        send(16'b0101010, 7, ma, mb);
        check("s2_mask_ov", ma, 16'h0050);
        check("s2_cnt_ov", cnt_a, 2);

        // 3: slot switch discards the bit on the switch edge
        lookfor_seq = 2'd0;
        cyc(1'b1, 1'b1);
        check("s3_cnt_clr", cnt_a, 0);
        send(16'b0111, 4, ma, mb);
        check("s3_mask_disc", ma, 16'h0000);
        send(16'b10111, 5, ma, mb);
        check("s3_mask", ma, 16'h0010);
        check("s3_cnt", cnt_a, 1);
        write_pat(2'd3, 5'b11111);
        check("s3_cnt_wr3", cnt_a, 1);
        write_pat(2'd0, 5'b10111);
        check("s3_cnt_wr0", cnt_a, 0);

        // 4: saturation on the 3-bit counter
        write_pat(2'd0, 5'b10100);
        overlap_en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            send(16'b10100, 5, ma, mb);
            check("s4_mask_a", ma, 16'h0010);
            check("s4_mask_b", mb, 16'h0010);
            check("s4_cnt_b", cnt_b, (k > 7) ? 7 : k);
            check("s4_sat_b", sat_b, k >= 7);
        end
        check("s4_cnt_a", cnt_a, 10);
        check("s4_sat_a", sat_a, 0);

        // 5: bubbles, then an unwritten slot
        write_pat(2'd0, 5'b10111);
        send_bubbled(16'b10111, 5, ma);
        check("s5_mask", ma, 16'h0010);
        check("s5_cnt", cnt_a, 1);
        lookfor_seq = 2'd2;
        cyc(1'b0, 1'b0);
        send(16'b10111, 5, ma, mb);
        check("s5_mask_unwr", ma, 16'h0000);
        check("s5_cnt_unwr", cnt_a, 0);

        // 6: reset mid-pattern wipes the bank
        lookfor_seq = 2'd0;
        cyc(1'b0, 1'b0);
        send(16'b101, 3, ma, mb);
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        send(16'b11, 2, ma, mb);
        check("s6_mask", ma, 16'h0000);
        check("s6_det", det_a, 0);
        check("s6_cnt", cnt_a, 0);
        check("s6_sat", sat_a, 0);
        send(16'b10111, 5, ma, mb);
        check("s6_mask_nowr", ma, 16'h0000);
        write_pat(2'd0, 5'b10111);
        send(16'b10111, 5, ma, mb);
        check("s6_mask_rewr", ma, 16'h0010);
        check("s6_cnt_rewr", cnt_a, 1);

        // Random phase, checked every cycle by the compare process
        for (int s = 0; s < NUM_PAT; s++) write_pat(s[1:0], 5'($urandom));
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            input_seq   = 1'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            pat_wr      = ($urandom_range(0, 24) == 0);
            pat_wr_sel  = 2'($urandom);
            pat_wr_data = 5'($urandom);
            reset       = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 39) == 0) lookfor_seq = 2'($urandom);
            if ($urandom_range(0, 29) == 0) overlap_en = ~overlap_en;
            if (reset) begin
                // Rewrite after reset happens through later random writes.
                pat_wr = 1'b0;
            end
        end
        @(negedge clk);
        reset  = 1'b0;
        pat_wr = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
